// File: rtl/wr_ptr_full_ctrl.sv
// Write-side pointer/full controller for an async FIFO (write clock domain).
// Optional overflow counter/flag enabled by defining WR_OVERFLOW_CNT_EN.
module wr_ptr_full_ctrl #(
   parameter int ADD_WIDTH = 3,
   parameter int AF_MARGIN = 1
) (
   input  logic                 wr_clk,
   input  logic                 wr_rst,
   input  logic                 wr_en,
   input  logic [ADD_WIDTH:0]   wr_rptr_sync,
   output logic                 wr_accept,
   output logic [ADD_WIDTH-1:0] wr_addr,
   output logic [ADD_WIDTH:0]   wr_ptr_gray,
   output logic                 wr_full,
   output logic                 wr_almost_full,
   output logic [ADD_WIDTH:0]   wr_level
`ifdef WR_OVERFLOW_CNT_EN
   ,
   output logic [7:0]           wr_ovf_cnt,
   output logic                 wr_ovf
`endif
);

   localparam int PW    = ADD_WIDTH + 1;
   localparam int DEPTH = 1 << ADD_WIDTH;
   localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

   logic [PW-1:0]        wbin_q, wbin_d;
   logic [PW-1:0]        gray_q, gray_d;
   logic [ADD_WIDTH-1:0] addr_q;
   logic                 full_q, full_d;
   logic                 af_q, af_d;
   logic [PW-1:0]        level_q, level_d;
   logic [PW-1:0]        rbin;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign wr_accept = wr_en & ~full_q;

   // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
   always_comb begin
      wbin_d  = wbin_q + {{ADD_WIDTH{1'b0}}, wr_accept};
      gray_d  = (wbin_d >> 1) ^ wbin_d;
      rbin    = gray2bin(wr_rptr_sync);
      // Full when write leads read by exactly DEPTH: top two Gray bits inverted, rest equal.
      full_d  = (gray_d == {~wr_rptr_sync[ADD_WIDTH:ADD_WIDTH-1], wr_rptr_sync[ADD_WIDTH-2:0]});
      level_d = wbin_d - rbin;
      af_d    = (level_d >= AF_LEVEL);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge wr_clk or negedge wr_rst) begin
      if (!wr_rst) begin
         wbin_q  <= '0;
         gray_q  <= '0;
         addr_q  <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         level_q <= '0;
      end else begin
         wbin_q  <= wbin_d;
         gray_q  <= gray_d;
         addr_q  <= wbin_d[ADD_WIDTH-1:0];
         full_q  <= full_d;
         af_q    <= af_d;
         level_q <= level_d;
      end
   end

   assign wr_addr        = addr_q;
   assign wr_ptr_gray    = gray_q;
   assign wr_full        = full_q;
   assign wr_almost_full = af_q;
   assign wr_level       = level_q;

`ifdef WR_OVERFLOW_CNT_EN
   logic [7:0] ovf_cnt_q;
   logic       ovf_q;

   // Counts cycles where the producer pushed into a full FIFO; saturates at 255.
   always_ff @(posedge wr_clk or negedge wr_rst) begin
      if (!wr_rst) begin
         ovf_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else if (wr_en && full_q) begin
         ovf_q <= 1'b1;
         if (ovf_cnt_q != 8'hFF) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
         end
      end
   end

   assign wr_ovf_cnt = ovf_cnt_q;
   assign wr_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Self-checking bench for wr_ptr_full_ctrl: directed scenarios plus random traffic
// against an occupancy-counting reference model.
module tb_wr_ptr_full_ctrl;

   localparam int AW    = 3;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 1 << AW;
   localparam int MOD   = 2 * DEPTH;
   localparam int AFM   = 1;

   logic          wr_clk = 1'b0;
   logic          wr_rst = 1'b1;
   logic          wr_en  = 1'b0;
   logic [PW-1:0] wr_rptr_sync = '0;
   logic          wr_accept;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_ptr_gray;
   logic          wr_full;
   logic          wr_almost_full;
   logic [PW-1:0] wr_level;
`ifdef WR_OVERFLOW_CNT_EN
   logic [7:0]    wr_ovf_cnt;
   logic          wr_ovf;
`endif

   wr_ptr_full_ctrl #(.ADD_WIDTH(AW), .AF_MARGIN(AFM)) dut (
      .wr_clk         (wr_clk),
      .wr_rst         (wr_rst),
      .wr_en          (wr_en),
      .wr_rptr_sync   (wr_rptr_sync),
      .wr_accept      (wr_accept),
      .wr_addr        (wr_addr),
      .wr_ptr_gray    (wr_ptr_gray),
      .wr_full        (wr_full),
      .wr_almost_full (wr_almost_full),
      .wr_level       (wr_level)
`ifdef WR_OVERFLOW_CNT_EN
      ,
      .wr_ovf_cnt     (wr_ovf_cnt),
      .wr_ovf         (wr_ovf)
`endif
   );

   always #5 wr_clk = ~wr_clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: count of accepted writes and of reads seen at the last edge.
   int m_w   = 0;
   int m_r_q = 0;
   int r_drv = 0;
   int m_ovf_cnt = 0;
   bit m_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] to_gray(input int b);
      logic [PW-1:0] v;
      v = PW'(b % MOD);
      return v ^ (v >> 1);
   endfunction

   function automatic int m_level();
      return (m_w - m_r_q + MOD) % MOD;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_addr"},  32'(wr_addr),        32'(m_w % DEPTH));
      check({tag, "_gray"},  32'(wr_ptr_gray),    32'(to_gray(m_w)));
      check({tag, "_level"}, 32'(wr_level),       32'(m_level()));
      check({tag, "_full"},  32'(wr_full),        32'(m_level() == DEPTH));
      check({tag, "_af"},    32'(wr_almost_full), 32'(m_level() >= DEPTH - AFM));
`ifdef WR_OVERFLOW_CNT_EN
      check({tag, "_ovfcnt"}, 32'(wr_ovf_cnt), 32'(m_ovf_cnt));
      check({tag, "_ovf"},    32'(wr_ovf),     32'(m_ovf));
`endif
   endtask

   // One write-clock cycle: drive at negedge, check accept, update model at posedge, check after.
   task automatic cyc(input string tag, input logic en, input int rc);
      bit exp_acc;
      @(negedge wr_clk);
      wr_en        = en;
      r_drv        = rc % MOD;
      wr_rptr_sync = to_gray(r_drv);
      #1;
      exp_acc = en && (m_level() != DEPTH);
      check({tag, "_accept"}, 32'(wr_accept), 32'(exp_acc));
      @(posedge wr_clk);
      if (en && !exp_acc) begin
         m_ovf = 1'b1;
         if (m_ovf_cnt < 255) m_ovf_cnt++;
      end
      m_w   = (m_w + int'(exp_acc)) % MOD;
      m_r_q = r_drv;
      #1;
      check_outputs(tag);
   endtask

   task automatic model_reset();
      m_w = 0; m_r_q = 0; r_drv = 0; m_ovf_cnt = 0; m_ovf = 1'b0;
   endtask

   initial begin
      logic [PW-1:0] prev_gray;
      int w1, w2;

      // Async reset before any clock edge.
      #2 wr_rst = 1'b0;
      #1;
      check_outputs("rst0");
      check("rst0_accept", 32'(wr_accept), 32'd0);
      @(negedge wr_clk);
      wr_rst = 1'b1;

      // 1: fill from empty with read pointer held at zero.
      for (int i = 0; i < 8; i++) begin
         cyc("tp1", 1'b1, 0);
         if (i == 5) check("tp1_af_lvl6", 32'(wr_almost_full), 32'd0);
         if (i == 6) check("tp1_af_lvl7", 32'(wr_almost_full), 32'd1);
      end
      check("tp1_gray_end", 32'(wr_ptr_gray), 32'b1100);
      check("tp1_full_end", 32'(wr_full), 32'd1);
      check("tp1_level_end", 32'(wr_level), 32'd8);

      // 2: writes while full are dropped.
      for (int i = 0; i < 3; i++) cyc("tp2", 1'b1, 0);
      check("tp2_gray_hold", 32'(wr_ptr_gray), 32'b1100);
`ifdef WR_OVERFLOW_CNT_EN
      check("tp2_ovf_cnt", 32'(wr_ovf_cnt), 32'd3);
      check("tp2_ovf", 32'(wr_ovf), 32'd1);
`endif

      // 3: one read frees a slot.
      cyc("tp3a", 1'b0, 1);
      check("tp3_full_clr", 32'(wr_full), 32'd0);
      check("tp3_level7", 32'(wr_level), 32'd7);
      cyc("tp3b", 1'b1, 1);

      // 4: read pointer trails the write pointer by two cycles, across the wrap.
      cyc("tp4_drain", 1'b0, m_w);
      w1 = m_w; w2 = m_w;
      prev_gray = wr_ptr_gray;
      for (int i = 0; i < 20; i++) begin
         cyc("tp4", 1'b1, w2);
         check("tp4_gray_1bit", 32'($countones(prev_gray ^ wr_ptr_gray) <= 1), 32'd1);
         check("tp4_nofull", 32'(wr_full), 32'd0);
         prev_gray = wr_ptr_gray;
         w2 = w1; w1 = m_w;
      end

      // 5: reset in the middle of a burst, between clock edges.
      for (int i = 0; i < 3; i++) begin
         cyc("tp5_burst", 1'b1, w2);
         w2 = w1; w1 = m_w;
      end
      @(negedge wr_clk);
      #2 wr_rst = 1'b0;
      #1;
      model_reset();
      check_outputs("tp5_rst");
      wr_en = 1'b0;
      wr_rptr_sync = '0;
      @(negedge wr_clk);
      #2 wr_rst = 1'b1;
      cyc("tp5_first", 1'b1, 0);
      check("tp5_addr1", 32'(wr_addr), 32'd1);
      check("tp5_gray1", 32'(wr_ptr_gray), 32'b0001);

      // 6: simultaneous write and read at level 5.
      for (int i = 0; i < 4; i++) cyc("tp6_fill", 1'b1, 0);
      check("tp6_level5_pre", 32'(wr_level), 32'd5);
      cyc("tp6", 1'b1, 1);
      check("tp6_level5", 32'(wr_level), 32'd5);
      check("tp6_nofull", 32'(wr_full), 32'd0);

      // Random traffic: write-heavy phase then read-heavy phase.
      for (int i = 0; i < 400; i++) begin
         int rc;
         bit en;
         int rd_pct;
         rd_pct = (i < 200) ? 25 : 70;
         en = ($urandom_range(99) < 70);
         rc = r_drv;
         if (((m_w - r_drv + MOD) % MOD) > 0 && $urandom_range(99) < rd_pct) rc = r_drv + 1;
         cyc("rnd", en, rc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
